lkh_destport_queue: RTL and testbench
=====================================

LKH_DESTPORT_QUEUE -- requirements
Module: lkh_destport_queue

Purpose: input-port receiver for look-ahead routing. Captures the look-ahead destination port carried in each incoming header flit, queues it per VC, and presents the head-of-line packet's port to the switch allocator until that packet's tail flit is read.

Interface -- parameters
REQ-001 SHALL have parameter V, default 4, meaning number of virtual channels per input port.
REQ-002 SHALL have parameter DSTPw, default 4, meaning width of the encoded destination-port field.
REQ-003 SHALL have parameter PKT_DEPTH, default 2, meaning maximum packets queued per VC (legal values 1..8).

Interface -- ports
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port flit_wr_i, input, 1, meaning a flit is written into the input buffer this cycle.
REQ-007 SHALL have port hdr_flg_i, input, 1, meaning the written flit is a header.
REQ-008 SHALL have port vc_num_i, input, V, meaning one-hot VC of the written flit.
REQ-009 SHALL have port lkdestport_i, input, DSTPw, meaning the look-ahead port field of the written header.
REQ-010 SHALL have port tail_rd_i, input, V, meaning one bit per VC: a tail flit is read from that VC this cycle.
REQ-011 SHALL have port destport_o, output, V*DSTPw, meaning head-of-queue port per VC, VC i at bits [(i+1)*DSTPw-1 : i*DSTPw].
REQ-012 SHALL have port destport_vld_o, output, V, meaning VC i queue non-empty.
REQ-013 SHALL have port full_o, output, V, meaning VC i holds PKT_DEPTH entries.
REQ-014 SHALL have port ovf_err_o, output, 1, meaning sticky push-when-full error.
REQ-015 SHALL have port udf_err_o, output, 1, meaning sticky pop-when-empty error.

Function
REQ-016 SHALL keep an independent circular FIFO per VC, PKT_DEPTH entries of DSTPw bits, with read/write pointers and a count of width log2(PKT_DEPTH+1).
REQ-017 SHALL push lkdestport_i into VC i when flit_wr_i=1, hdr_flg_i=1 and vc_num_i[i]=1.
REQ-018 SHALL ignore non-header writes; body and tail writes change no state.
REQ-019 SHALL pop VC i when tail_rd_i[i]=1; any number of VCs may pop in the same cycle.
REQ-020 SHALL present the new pushed value on destport_o one cycle after the push edge (registered, latency 1) when the queue was empty.
REQ-021 SHALL drive destport_o slice i = head entry while destport_vld_o[i]=1; value when invalid is don't-care but must hold the last slot contents (no X after reset).
REQ-022 SHALL, on simultaneous push and pop of the same non-empty VC, perform both, leaving count unchanged and advancing the head.
REQ-023 SHALL, on simultaneous push and pop of the same empty VC, ignore the pop, perform the push, and set udf_err_o.
REQ-024 SHALL, on push to a full VC without a same-cycle pop, drop the entry and set ovf_err_o; push to a full VC with a same-cycle pop succeeds.
REQ-025 SHALL, on pop of an empty VC, leave pointers unchanged and set udf_err_o.
REQ-026 SHALL wrap pointers from PKT_DEPTH-1 to 0, including non-power-of-two depths.
REQ-027 SHALL treat a single-flit packet (header written, tail later read) as one push and one pop; same-cycle header write and tail read on one VC follows REQ-022/REQ-023.
REQ-028 SHALL derive full_o and destport_vld_o combinationally from registered counts only.
REQ-029 SHALL treat a non-one-hot vc_num_i with a header write as an ovf_err_o event and push nothing.

Reset
REQ-030 SHALL, while reset=1, asynchronously clear all pointers, counts, storage, ovf_err_o and udf_err_o: destport_o=0, destport_vld_o=0, full_o=0.
REQ-031 SHALL discard all queued entries on reset asserted mid-packet; first push after deassertion behaves as from empty.

Verification
REQ-032 SHALL cover: header VC1 port 4'h3 -> next cycle destport_vld_o=4'b0010, slice1=3; tail_rd_i=4'b0010 -> next cycle vld=0.
REQ-033 SHALL cover: PKT_DEPTH=2, headers VC0 ports 1,2,5 -> full_o[0]=1 after second, third dropped, ovf_err_o=1; two pops yield 1 then 2.
REQ-034 SHALL cover: VC2 holding port 6, same-cycle header port 7 and tail_rd_i[2] -> count stays 1, head=7, no error flags.
REQ-035 SHALL cover: tail_rd_i=4'b1000 on empty VC3 -> udf_err_o=1, all other state unchanged.
REQ-036 SHALL cover: all VCs holding entries, reset pulsed mid-cycle -> outputs zero immediately (before next clk edge); new header after release gives latency 1.
REQ-037 SHALL cover: PKT_DEPTH=3, 10 push/pop pairs on one VC -> FIFO order preserved across pointer wrap.

Source files
------------

// File: rtl/lkh_destport_queue.sv
// Look-ahead destination port queue: one small circular FIFO per VC holding the
// routed output port of each queued packet, head presented to the switch allocator.
module lkh_destport_queue #(
    parameter int V         = 4,
    parameter int DSTPw     = 4,
    parameter int PKT_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flit_wr_i,
    input  logic               hdr_flg_i,
    input  logic [V-1:0]       vc_num_i,
    input  logic [DSTPw-1:0]   lkdestport_i,
    input  logic [V-1:0]       tail_rd_i,
    output logic [V*DSTPw-1:0] destport_o,
    output logic [V-1:0]       destport_vld_o,
    output logic [V-1:0]       full_o,
    output logic               ovf_err_o,
    output logic               udf_err_o
);

    localparam int PTRw = (PKT_DEPTH > 1) ? $clog2(PKT_DEPTH) : 1;
    localparam int CNTw = $clog2(PKT_DEPTH + 1);
    localparam logic [PTRw-1:0] LAST_PTR = PTRw'(PKT_DEPTH - 1);
    localparam logic [CNTw-1:0] FULL_CNT = CNTw'(PKT_DEPTH);

    logic [DSTPw-1:0] mem    [V][PKT_DEPTH];
    logic [PTRw-1:0]  rd_ptr [V];
    logic [PTRw-1:0]  wr_ptr [V];
    logic [CNTw-1:0]  count  [V];

    logic         hdr_wr;
    logic         vc_onehot;
    logic [V-1:0] empty;
    logic [V-1:0] push_req;
    logic [V-1:0] do_push;
    logic [V-1:0] do_pop;
    logic         ovf_evt;
    logic         udf_evt;

    // Explicit wrap so non-power-of-two depths never index past the last slot.
    function automatic logic [PTRw-1:0] ptr_inc(input logic [PTRw-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTRw'(1);
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        destport_o     = '0;
        destport_vld_o = '0;
        full_o         = '0;
        empty          = '0;
        push_req       = '0;
        do_push        = '0;
        do_pop         = '0;
        hdr_wr         = flit_wr_i & hdr_flg_i;
        vc_onehot      = (vc_num_i != '0) && ((vc_num_i & (vc_num_i - V'(1))) == '0);
        ovf_evt        = hdr_wr & ~vc_onehot;
        udf_evt        = 1'b0;
        for (int i = 0; i < V; i++) begin
            empty[i]          = (count[i] == '0);
            full_o[i]         = (count[i] == FULL_CNT);
            destport_vld_o[i] = ~empty[i];
            push_req[i]       = hdr_wr & vc_onehot & vc_num_i[i];
            // A pop frees a slot in the same cycle, so push-when-full with a pop is legal.
            do_push[i]        = push_req[i] & (~full_o[i] | tail_rd_i[i]);
            do_pop[i]         = tail_rd_i[i] & ~empty[i];
            ovf_evt           = ovf_evt | (push_req[i] & full_o[i] & ~tail_rd_i[i]);
            udf_evt           = udf_evt | (tail_rd_i[i] & empty[i]);
            destport_o[i*DSTPw +: DSTPw] = mem[i][rd_ptr[i]];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: storage is reset too, so an invalid slice reads 0 rather than X.
            for (int i = 0; i < V; i++) begin
                for (int j = 0; j < PKT_DEPTH; j++) begin
                    mem[i][j] <= '0;
                end
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            ovf_err_o <= 1'b0;
            udf_err_o <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all per-VC updates based on pre-edge state.
            ovf_err_o <= ovf_err_o | ovf_evt;
            udf_err_o <= udf_err_o | udf_evt;
            for (int i = 0; i < V; i++) begin
                if (do_push[i]) begin
                    mem[i][wr_ptr[i]] <= lkdestport_i;
                    wr_ptr[i]         <= ptr_inc(wr_ptr[i]);
                end
                if (do_pop[i]) begin
                    rd_ptr[i] <= ptr_inc(rd_ptr[i]);
                end
                count[i] <= count[i] + CNTw'(do_push[i]) - CNTw'(do_pop[i]);
            end
        end
    end

endmodule

// File: tb/tb_lkh_destport_queue.sv
// Directed self-checking bench for lkh_destport_queue: a depth-2 instance for the
// main scenarios and a depth-3 instance for pointer wrap, with a scoreboard queue.
module tb_lkh_destport_queue;

    localparam int V     = 4;
    localparam int DSTPw = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             flit_wr, hdr_flg;
    logic [V-1:0]     vc_num, tail_rd;
    logic [DSTPw-1:0] lkport;
    logic [V*DSTPw-1:0] destport;
    logic [V-1:0]     vld, full;
    logic             ovf, udf;

    logic             b_flit_wr, b_hdr_flg;
    logic [V-1:0]     b_vc_num, b_tail_rd;
    logic [DSTPw-1:0] b_lkport;
    logic [V*DSTPw-1:0] b_destport;
    logic [V-1:0]     b_vld, b_full;
    logic             b_ovf, b_udf;

    int checks = 0;
    int errors = 0;
    logic [DSTPw-1:0] sb[$];
    logic [DSTPw-1:0] exp_v;

    always #5 clk = ~clk;

    lkh_destport_queue #(.V(V), .DSTPw(DSTPw), .PKT_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .flit_wr_i(flit_wr), .hdr_flg_i(hdr_flg),
        .vc_num_i(vc_num), .lkdestport_i(lkport), .tail_rd_i(tail_rd),
        .destport_o(destport), .destport_vld_o(vld), .full_o(full),
        .ovf_err_o(ovf), .udf_err_o(udf)
    );

    lkh_destport_queue #(.V(V), .DSTPw(DSTPw), .PKT_DEPTH(3)) dut3 (
        .clk(clk), .reset(reset), .flit_wr_i(b_flit_wr), .hdr_flg_i(b_hdr_flg),
        .vc_num_i(b_vc_num), .lkdestport_i(b_lkport), .tail_rd_i(b_tail_rd),
        .destport_o(b_destport), .destport_vld_o(b_vld), .full_o(b_full),
        .ovf_err_o(b_ovf), .udf_err_o(b_udf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        flit_wr = 1'b0; hdr_flg = 1'b0; vc_num = '0; tail_rd = '0; lkport = '0;
        b_flit_wr = 1'b0; b_hdr_flg = 1'b0; b_vc_num = '0; b_tail_rd = '0; b_lkport = '0;
    endtask

    task automatic hdr(input logic [V-1:0] vc, input logic [DSTPw-1:0] p);
        flit_wr = 1'b1; hdr_flg = 1'b1; vc_num = vc; lkport = p;
    endtask

    task automatic b_hdr(input logic [DSTPw-1:0] p);
        b_flit_wr = 1'b1; b_hdr_flg = 1'b1; b_vc_num = 4'b0001; b_lkport = p;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        sb.delete();
    endtask

    initial begin
        flit_wr = 1'b0; hdr_flg = 1'b0; vc_num = '0; tail_rd = '0; lkport = '0;
        b_flit_wr = 1'b0; b_hdr_flg = 1'b0; b_vc_num = '0; b_tail_rd = '0; b_lkport = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        check("rst_destport", destport, 32'h0);
        check("rst_vld", vld, 32'h0);
        check("rst_full", full, 32'h0);
        check("rst_errs", {ovf, udf}, 32'h0);
        reset = 1'b0;
        tick();

        // Single packet on VC1
        hdr(4'b0010, 4'h3);
        tick();
        check("vc1_vld", vld, 32'h2);
        check("vc1_slice", destport[7:4], 32'h3);
        tail_rd = 4'b0010;
        tick();
        check("vc1_pop_vld", vld, 32'h0);

        // Body flits change nothing
        flit_wr = 1'b1; hdr_flg = 1'b0; vc_num = 4'b0001; lkport = 4'hF;
        tick();
        check("body_ignored", {vld, ovf, udf}, 32'h0);

        // Fill VC0, overflow, drain in order
        foreach (sb[i]) sb.delete(i);
        hdr(4'b0001, 4'h1); sb.push_back(4'h1);
        tick();
        check("vc0_not_full", full, 32'h0);
        hdr(4'b0001, 4'h2); sb.push_back(4'h2);
        tick();
        check("vc0_full", full, 32'h1);
        hdr(4'b0001, 4'h5);
        tick();
        check("vc0_ovf", {ovf, udf}, 32'h2);
        check("vc0_full_kept", full, 32'h1);
        for (int k = 0; k < 2; k++) begin
            exp_v = sb.pop_front();
            check("vc0_drain_head", destport[3:0], {28'h0, exp_v});
            tail_rd = 4'b0001;
            tick();
        end
        check("vc0_drained", vld, 32'h0);

        // Same-cycle push and pop on non-empty VC2
        pulse_reset();
        hdr(4'b0100, 4'h6);
        tick();
        check("vc2_head6", destport[11:8], 32'h6);
        hdr(4'b0100, 4'h7); tail_rd = 4'b0100;
        tick();
        check("vc2_pp_head", destport[11:8], 32'h7);
        check("vc2_pp_state", {vld, full, ovf, udf}, {22'h0, 4'b0100, 4'b0000, 2'b00});
        tail_rd = 4'b0100;
        tick();
        check("vc2_count_was_1", vld, 32'h0);

        // Pop of empty VC3 with VC0 occupied
        hdr(4'b0001, 4'h9);
        tick();
        tail_rd = 4'b1000;
        tick();
        check("udf_flag", {ovf, udf}, 32'h1);
        check("udf_other_state", {vld, full, destport[3:0]}, {24'h0, 4'b0001, 4'b0000, 4'h9});

        // Push and pop of empty VC3 in the same cycle
        pulse_reset();
        hdr(4'b1000, 4'hA); tail_rd = 4'b1000;
        tick();
        check("empty_pp_push", {vld, destport[15:12]}, {24'h0, 4'b1000, 4'hA});
        check("empty_pp_udf", {ovf, udf}, 32'h1);

        // Push to full VC1 with a same-cycle pop succeeds
        pulse_reset();
        hdr(4'b0010, 4'h1); tick();
        hdr(4'b0010, 4'h2); tick();
        hdr(4'b0010, 4'h3); tail_rd = 4'b0010;
        tick();
        check("full_pp_head", destport[7:4], 32'h2);
        check("full_pp_state", {full, ovf, udf}, {26'h0, 4'b0010, 2'b00});
        tail_rd = 4'b0010;
        tick();
        check("full_pp_next", destport[7:4], 32'h3);

        // Non-one-hot VC select is an overflow event and pushes nothing
        pulse_reset();
        hdr(4'b0011, 4'h4);
        tick();
        check("nonhot_ovf", {vld, ovf, udf}, {26'h0, 4'b0000, 2'b10});

        // Asynchronous reset with every VC occupied
        for (int k = 0; k < V; k++) begin
            hdr(V'(1) << k, DSTPw'(k + 8));
            tick();
        end
        check("all_vld", vld, 32'hF);
        check("all_ports", destport, 32'hBA98);
        #2 reset = 1'b1;
        #1;
        check("async_rst_out", {destport, vld, full}, 32'h0);
        #1 reset = 1'b0;
        sb.delete();
        hdr(4'b0100, 4'h5);
        tick();
        check("post_rst_push", {vld, destport}, {12'h0, 4'b0100, 16'h0500});

        // Depth-3 instance: FIFO order across pointer wrap
        b_hdr(4'h1); sb.push_back(4'h1); tick();
        b_hdr(4'h2); sb.push_back(4'h2); tick();
        for (int k = 0; k < 10; k++) begin
            exp_v = sb.pop_front();
            check("wrap_head", b_destport[3:0], {28'h0, exp_v});
            b_hdr(DSTPw'(k + 3)); sb.push_back(DSTPw'(k + 3));
            b_tail_rd = 4'b0001;
            tick();
        end
        b_hdr(4'hE); sb.push_back(4'hE);
        tick();
        check("wrap_full", b_full, 32'h1);
        while (sb.size() > 0) begin
            exp_v = sb.pop_front();
            check("wrap_drain", b_destport[3:0], {28'h0, exp_v});
            b_tail_rd = 4'b0001;
            tick();
        end
        check("wrap_end", {b_vld, b_ovf, b_udf}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
